// File: rtl/cpu_reg_file.sv
// General-purpose register file: one write port with load/inc/dec/clear modify modes,
// two registered write-first read ports, and carry/zero flags from the last accepted write.
module cpu_reg_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              carry,
  output logic              zero
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpDec  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  logic              wr_accept;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] res;
  logic              res_carry;

  assign wr_accept = we && (32'(waddr) < NUM_REGS) && !((ZERO_R0 != 0) && (waddr == '0));

  // Old value is only meaningful for in-range addresses; out-of-range never commits.
  always_comb begin
    old_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(waddr) == i) old_val = regs_q[i];
    end
  end

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    unique case (op)
      OpLoad: begin
        res       = wdata;
        res_carry = 1'b0;
      end
      OpInc: begin
        res       = old_val + One;
        res_carry = &old_val;
      end
      OpDec: begin
        res       = old_val - One;
        res_carry = (old_val == '0);
      end
      OpClr: begin
        res       = '0;
        res_carry = 1'b0;
      end
      default: begin
        res       = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_accept && (32'(waddr) == i)) regs_d[i] = res;
      if ((ZERO_R0 != 0) && (i == 0)) regs_d[i] = '0;
    end
  end

  // Reads sample the post-write array so a same-cycle write is bypassed to the ports.
  always_comb begin
    ra_d = '0;
    rb_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(ra_addr) == i) ra_d = regs_d[i];
      if (32'(rb_addr) == i) rb_d = regs_d[i];
    end
  end

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (wr_accept) begin
      carry_d = res_carry;
      zero_d  = (res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign ra_data = ra_q;
  assign rb_data = rb_q;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_cpu_reg_file.sv
// Self-checking bench for cpu_reg_file: directed scenarios plus randomized traffic against an
// array-based reference model, on a default instance and a NUM_REGS=3 / ZERO_R0=1 instance.
module tb_cpu_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] op;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] ra_addr;
  logic [1:0] rb_addr;

  logic [7:0] o_ra [2];
  logic [7:0] o_rb [2];
  logic       o_c  [2];
  logic       o_z  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance.
  int unsigned m_regs [2][4];
  bit          m_c    [2];
  bit          m_z    [2];
  int unsigned nregs  [2] = '{4, 3};
  bit          zr     [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  cpu_reg_file #(.DATA_W(8), .NUM_REGS(4), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .we(we), .op(op), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(o_ra[0]), .rb_data(o_rb[0]), .carry(o_c[0]), .zero(o_z[0])
  );

  cpu_reg_file #(.DATA_W(8), .NUM_REGS(3), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .op(op), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(o_ra[1]), .rb_data(o_rb[1]), .carry(o_c[1]), .zero(o_z[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_regs[k][i] = 0;
      m_c[k] = 1'b0;
      m_z[k] = 1'b1;
    end
  endtask

  function automatic logic [7:0] model_read(int k, int unsigned a);
    if (a >= nregs[k] || (zr[k] && a == 0)) return 8'h00;
    return 8'(m_regs[k][a]);
  endfunction

  task automatic model_write();
    int unsigned old, res;
    bit c;
    for (int k = 0; k < 2; k++) begin
      if (we && (int'(waddr) < int'(nregs[k])) && !(zr[k] && waddr == 0)) begin
        old = m_regs[k][waddr];
        case (op)
          2'd0:    begin res = wdata;            c = 1'b0;          end
          2'd1:    begin res = (old + 1) % 256;  c = (old == 255);  end
          2'd2:    begin res = (old + 255) % 256; c = (old == 0);   end
          default: begin res = 0;                c = 1'b0;          end
        endcase
        m_regs[k][waddr] = res;
        m_c[k] = c;
        m_z[k] = (res == 0);
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, and leave time 1 ns past the edge.
  task automatic step(input logic w, input logic [1:0] o, input logic [1:0] wa,
                      input logic [7:0] wd, input logic [1:0] a, input logic [1:0] b);
    we = w; op = o; waddr = wa; wdata = wd; ra_addr = a; rb_addr = b;
    @(posedge clk);
    model_write();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; op = 2'd0; waddr = 2'd0; wdata = 8'hAA; ra_addr = 2'd0; rb_addr = 2'd0;
    model_reset();
    #12;
    n_checks++;
    if ({o_ra[0], o_rb[0], o_c[0], o_z[0]} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got ra=%h rb=%h c=%b z=%b want 00 00 0 1",
               o_ra[0], o_rb[0], o_c[0], o_z[0]);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 2'd0, 8'h00, 2'(i), 2'(3 - i));
      n_checks++;
      if (o_ra[0] !== 8'h00 || o_rb[0] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read r%0d got ra=%h rb=%h want 00", i, o_ra[0], o_rb[0]);
      end
    end
  endtask

  task automatic test_load_bypass();
    step(1'b1, 2'd0, 2'd2, 8'h5A, 2'd2, 2'd0);
    n_checks++;
    if ({o_ra[0], o_c[0], o_z[0]} !== {8'h5A, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_bypass got ra=%h c=%b z=%b want 5a 0 0", o_ra[0], o_c[0], o_z[0]);
    end
    step(1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd2);
    n_checks++;
    if (o_rb[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL load_readb got rb=%h want 5a", o_rb[0]);
    end
  endtask

  task automatic test_inc_wrap();
    step(1'b1, 2'd0, 2'd1, 8'hFE, 2'd1, 2'd1);
    step(1'b1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd1);
    n_checks++;
    if ({o_ra[0], o_c[0], o_z[0]} !== {8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL inc_to_ff got ra=%h c=%b z=%b want ff 0 0", o_ra[0], o_c[0], o_z[0]);
    end
    step(1'b1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd1);
    n_checks++;
    if ({o_ra[0], o_rb[0], o_c[0], o_z[0]} !== {8'h00, 8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL inc_wrap got ra=%h rb=%h c=%b z=%b want 00 00 1 1",
               o_ra[0], o_rb[0], o_c[0], o_z[0]);
    end
  endtask

  task automatic test_dec_clr();
    step(1'b1, 2'd1, 2'd3, 8'h00, 2'd3, 2'd3);  // make R3 nonzero first
    step(1'b1, 2'd3, 2'd3, 8'h99, 2'd3, 2'd3);
    n_checks++;
    if ({o_ra[0], o_c[0], o_z[0]} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL clr got ra=%h c=%b z=%b want 00 0 1", o_ra[0], o_c[0], o_z[0]);
    end
    step(1'b1, 2'd2, 2'd3, 8'h00, 2'd3, 2'd3);
    n_checks++;
    if ({o_ra[0], o_c[0], o_z[0]} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dec_borrow got ra=%h c=%b z=%b want ff 1 0", o_ra[0], o_c[0], o_z[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd3, 2'd3, 8'h00, 2'd3, 2'd1);
      n_checks++;
      if ({o_ra[0], o_c[0], o_z[0]} !== {8'hFF, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL flag_hold cyc%0d got ra=%h c=%b z=%b want ff 1 0",
                 i, o_ra[0], o_c[0], o_z[0]);
      end
    end
  endtask

  task automatic test_zero_r0_oor();
    step(1'b1, 2'd0, 2'd1, 8'h10, 2'd1, 2'd1);
    step(1'b1, 2'd0, 2'd0, 8'h77, 2'd0, 2'd0);
    n_checks++;
    if ({o_ra[1], o_rb[1], o_c[1], o_z[1]} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_r0 got ra=%h rb=%h c=%b z=%b want 00 00 0 0",
               o_ra[1], o_rb[1], o_c[1], o_z[1]);
    end
    n_checks++;
    if (o_ra[0] !== 8'h77) begin
      n_fail++;
      $display("FAIL r0_writable got ra=%h want 77", o_ra[0]);
    end
    step(1'b1, 2'd0, 2'd3, 8'h77, 2'd3, 2'd1);
    n_checks++;
    if ({o_ra[1], o_rb[1], o_c[1], o_z[1]} !== {8'h00, 8'h10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL out_of_range got ra=%h rb=%h c=%b z=%b want 00 10 0 0",
               o_ra[1], o_rb[1], o_c[1], o_z[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] pick;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       pick = 8'h00;
        1:       pick = 8'hFF;
        default: pick = 8'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           pick, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_ra[k], o_rb[k], o_c[k], o_z[k]} !==
            {model_read(k, ra_addr), model_read(k, rb_addr), m_c[k], m_z[k]}) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d got ra=%h rb=%h c=%b z=%b want %h %h %b %b",
                   k, n, o_ra[k], o_rb[k], o_c[k], o_z[k],
                   model_read(k, ra_addr), model_read(k, rb_addr), m_c[k], m_z[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'd0, 2'd0, 8'h40, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 2'd0, 8'h00, 2'd0, 2'd0);
    n_checks++;
    if (o_ra[0] !== 8'h43) begin
      n_fail++;
      $display("FAIL inc_run got ra=%h want 43", o_ra[0]);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({o_ra[0], o_rb[0], o_c[0], o_z[0]} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset got ra=%h rb=%h c=%b z=%b want 00 00 0 1",
               o_ra[0], o_rb[0], o_c[0], o_z[0]);
    end
    #2 rst = 1'b1;
    step(1'b1, 2'd1, 2'd0, 8'h00, 2'd0, 2'd0);
    n_checks++;
    if ({o_ra[0], o_c[0], o_z[0]} !== {8'h01, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_inc got ra=%h c=%b z=%b want 01 0 0", o_ra[0], o_c[0], o_z[0]);
    end
  endtask

  initial begin
    test_reset();
    test_load_bypass();
    test_inc_wrap();
    test_dec_clr();
    test_zero_r0_oor();
    test_random();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_reg_file.md
# cpu_reg_file

Parametrised general-purpose register file for the 8-bit CPU datapath, replacing the single ALU-output latch. It holds NUM_REGS registers of DATA_W bits and has one write port with an in-place modify mode (load, increment, decrement, clear). Two registered read ports feed the ALU operands. Registered carry and zero flags report the result of the last write for the control unit.

## Interface
- DATA_W, 8, register width in bits (≥2)
- NUM_REGS, 4, number of registers (≥2, need not be a power of two)
- ADDR_W, $clog2(NUM_REGS), address width
- ZERO_R0, 0, when 1 register 0 is hardwired to zero

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- we  input  1  write enable for this cycle
- op  input  2  write mode: 00 LOAD, 01 INC, 10 DEC, 11 CLR
- waddr  input  ADDR_W  write/modify target register
- wdata  input  DATA_W  load value; used only by LOAD
- ra_addr  input  ADDR_W  read port A address
- rb_addr  input  ADDR_W  read port B address
- ra_data  output  DATA_W  read port A data, registered
- rb_data  output  DATA_W  read port B data, registered
- carry  output  1  carry/borrow of the last accepted write
- zero  output  1  1 when the result of the last accepted write was 0

## Operation
- Reset (rst=0, asynchronous assert and release handled by flops):
  - all registers, ra_data and rb_data go to 0
  - carry goes to 0, zero goes to 1
- Accepted write: we=1, waddr < NUM_REGS, and not (ZERO_R0=1 and waddr=0).
- Result by op, with old = current value of reg[waddr]:
  - LOAD: wdata; carry←0
  - INC: old+1 mod 2^DATA_W; carry←1 only if old was all-ones (result 0)
  - DEC: old−1 mod 2^DATA_W; carry←1 only if old was 0 (result all-ones)
  - CLR: 0; carry←0
- On every accepted write, zero←(result==0).
- No accepted write (we=0, address out of range, or R0 write with ZERO_R0=1):
  - no register changes
  - carry and zero hold
- Reads, every cycle:
  - ra_data←value of reg[ra_addr] after this edge's write (write-first)
  - rb_data likewise for rb_addr
  - If a read address equals an accepted waddr in the same cycle, that port returns the new result, not the old value.
- Out-of-range read address reads 0. Register 0 reads 0 when ZERO_R0=1.
- Both ports may address the same register; both return the same value.

## Timing
- Write latency: the result is visible in the register and flags one edge after we is sampled high.
- Read latency: one cycle. Address presented in cycle N gives data on the outputs after edge N.
- Read-after-write to the same register in the same cycle returns the new value at the same edge. There is no extra stall.
- Back-to-back INC/DEC on one register every cycle: each cycle operates on the value written the previous cycle. N cycles of INC from v gives v+N mod 2^DATA_W.
- Reset asserted mid-operation: a write in flight is discarded and all outputs go to their reset values immediately (asynchronous). The first edge after rst returns to 1 behaves as a normal cycle.
- No handshake and no backpressure: every accepted write completes in one cycle.

## Test plan
- Reset: drive rst=0 with we=1, op=LOAD, wdata=8'hAA → all outputs 0, carry=0, zero=1. After release, reading R0–R3 returns 8'h00.
- Load and bypass: LOAD 8'h5A to R2 with ra_addr=2 in the same cycle → ra_data=8'h5A after that edge, zero=0, carry=0. Next cycle rb_addr=2 → rb_data=8'h5A.
- Increment wrap: LOAD 8'hFE to R1, then INC R1 twice → R1 reads 8'hFF (carry=0, zero=0), then 8'h00 (carry=1, zero=1).
- Decrement borrow and CLR: CLR R3 → zero=1, carry=0. Then DEC R3 → R3=8'hFF, carry=1, zero=0. Then we=0 for 3 cycles → flags hold at carry=1, zero=0.
- ZERO_R0=1 and out-of-range address: with NUM_REGS=3, LOAD 8'h77 to R0 and to address 3 → both reads return 8'h00 and flags unchanged.
- Reset mid-sequence: run continuous INC on R0, assert rst between clock edges → outputs go to 0 immediately. After release, the first INC makes R0=8'h01.
